// File: rtl/pagerank_dmp_serial.sv
// pagerank_dmp_serial: serial PageRank engine. One graph slot is scattered per
// cycle into per-node accumulators, then all ranks are updated in one cycle.
// The engine repeats until the summed rank change drops below the threshold
// or until the 1000-iteration cap is reached.

module pagerank_dmp_compute #(
    parameter int NUM_HW_THREADS     = 20,
    parameter int MAX_PARTITION_SIZE = 1,
    parameter int NODES_IN_GRAPH     = 20,
    parameter int STREAM_SIZE        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pagerank_enable,
    input  logic [31:0] source_id  [NUM_HW_THREADS][MAX_PARTITION_SIZE],
    input  logic [31:0] out_degree [NUM_HW_THREADS][MAX_PARTITION_SIZE],
    input  logic [31:0] dest_id    [NUM_HW_THREADS][MAX_PARTITION_SIZE][STREAM_SIZE],
    input  real         damping_factor,
    input  real         threshold,
    output real         pagerank   [NODES_IN_GRAPH],
    output logic        pagerank_complete
);
    localparam int  SLOTS     = NUM_HW_THREADS * MAX_PARTITION_SIZE;
    localparam int  MAX_ITER  = 1000;
    localparam real INIT_RANK = 1.0 / real'(NODES_IN_GRAPH);

    typedef enum logic [2:0] {IDLE, INIT, SCATTER, UPDATE, DONE} state_t;

    state_t      state_q, state_d;
    real         rank       [NODES_IN_GRAPH];
    real         accum      [NODES_IN_GRAPH];
    real         accum_next [NODES_IN_GRAPH];
    real         new_rank   [NODES_IN_GRAPH];
    real         delta;
    real         delta_next;
    integer      iteration_number;
    logic [31:0] slot_q;
    logic [31:0] cur_src;
    logic [31:0] cur_deg;
    logic [31:0] cur_dest [STREAM_SIZE];
    real         src_rank;
    real         share;
    real         diff;
    real         base;
    logic        last_slot;
    logic        converged;

    assign pagerank          = rank;
    assign pagerank_complete = (state_q == DONE);
    assign last_slot         = (slot_q == 32'(SLOTS - 1));

    // Select the slot currently being scattered (row-major thread, partition).
    always_comb begin
        cur_src = '0;
        cur_deg = '0;
        for (int unsigned k = 0; k < STREAM_SIZE; k++) cur_dest[k] = '0;
        for (int unsigned t = 0; t < NUM_HW_THREADS; t++) begin
            for (int unsigned p = 0; p < MAX_PARTITION_SIZE; p++) begin
                if (32'(t * MAX_PARTITION_SIZE + p) == slot_q) begin
                    cur_src = source_id[t][p];
                    cur_deg = out_degree[t][p];
                    for (int unsigned k = 0; k < STREAM_SIZE; k++) cur_dest[k] = dest_id[t][p][k];
                end
            end
        end
    end

    // Spread the source rank over its valid, in-range out-edges.
    always_comb begin
        src_rank = 0.0;
        for (int unsigned v = 0; v < NODES_IN_GRAPH; v++) begin
            if (cur_src == 32'(v)) src_rank = rank[v];
        end
        share = (cur_deg != '0) ? src_rank / real'(cur_deg) : 0.0;
        accum_next = accum;
        if (cur_src < 32'(NODES_IN_GRAPH) && cur_deg != '0) begin
            for (int unsigned k = 0; k < STREAM_SIZE; k++) begin
                if (32'(k) < cur_deg) begin
                    for (int unsigned v = 0; v < NODES_IN_GRAPH; v++) begin
                        if (cur_dest[k] == 32'(v)) accum_next[v] = accum_next[v] + share;
                    end
                end
            end
        end
    end

    // Damped rank update and total absolute change across all nodes.
    always_comb begin
        base       = (1.0 - damping_factor) / real'(NODES_IN_GRAPH);
        delta_next = 0.0;
        diff       = 0.0;
        for (int unsigned v = 0; v < NODES_IN_GRAPH; v++) begin
            new_rank[v] = base + damping_factor * accum[v];
            diff        = new_rank[v] - rank[v];
            delta_next  = delta_next + ((diff < 0.0) ? -diff : diff);
        end
        converged = (delta_next < threshold) || (iteration_number >= MAX_ITER - 1);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pagerank_enable) state_d = INIT;
            INIT:    state_d = SCATTER;
            SCATTER: if (last_slot) state_d = UPDATE;
            UPDATE:  state_d = converged ? DONE : SCATTER;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Rank, accumulator, slot and iteration registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rank             <= '{default: 0.0};
            accum            <= '{default: 0.0};
            delta            <= 0.0;
            iteration_number <= 0;
            slot_q           <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    rank             <= '{default: INIT_RANK};
                    accum            <= '{default: 0.0};
                    delta            <= 0.0;
                    iteration_number <= 0;
                    slot_q           <= '0;
                end
                SCATTER: begin
                    accum  <= accum_next;
                    slot_q <= last_slot ? '0 : slot_q + 32'd1;
                end
                UPDATE: begin
                    rank  <= new_rank;
                    delta <= delta_next;
                    if (!converged) begin
                        iteration_number <= iteration_number + 1;
                        accum            <= '{default: 0.0};
                        slot_q           <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

module pagerank_dmp_serial #(
    parameter int NUM_HW_THREADS     = 20,
    parameter int MAX_PARTITION_SIZE = 1,
    parameter int NODES_IN_GRAPH     = 20,
    parameter int STREAM_SIZE        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pagerank_enable,
    input  logic [31:0] source_id  [NUM_HW_THREADS][MAX_PARTITION_SIZE],
    input  logic [31:0] out_degree [NUM_HW_THREADS][MAX_PARTITION_SIZE],
    input  logic [31:0] dest_id    [NUM_HW_THREADS][MAX_PARTITION_SIZE][STREAM_SIZE],
    input  real         damping_factor,
    input  real         threshold,
    output real         pagerank   [NODES_IN_GRAPH],
    output logic        pagerank_complete
);
    pagerank_dmp_compute #(
        .NUM_HW_THREADS    (NUM_HW_THREADS),
        .MAX_PARTITION_SIZE(MAX_PARTITION_SIZE),
        .NODES_IN_GRAPH    (NODES_IN_GRAPH),
        .STREAM_SIZE       (STREAM_SIZE)
    ) pagerank_computation (
        .clock            (clock),
        .reset_n          (reset_n),
        .pagerank_enable  (pagerank_enable),
        .source_id        (source_id),
        .out_degree       (out_degree),
        .dest_id          (dest_id),
        .damping_factor   (damping_factor),
        .threshold        (threshold),
        .pagerank         (pagerank),
        .pagerank_complete(pagerank_complete)
    );
endmodule

// File: tb/tb_pagerank_dmp_serial.sv
// Directed bench for pagerank_dmp_serial with hand-computed expectations.
module tb_pagerank_dmp_serial;
    localparam int T = 20;
    localparam int P = 1;
    localparam int N = 20;
    localparam int S = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pagerank_enable;
    logic [31:0] source_id  [T][P];
    logic [31:0] out_degree [T][P];
    logic [31:0] dest_id    [T][P][S];
    real         damping_factor;
    real         threshold;
    real         pagerank   [N];
    logic        pagerank_complete;

    int  vectors     = 0;
    int  miscompares = 0;
    real ref_rank [N];
    int  ref_cycles;

    always #5 clock = ~clock;

    pagerank_dmp_serial dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pagerank_enable  (pagerank_enable),
        .source_id        (source_id),
        .out_degree       (out_degree),
        .dest_id          (dest_id),
        .damping_factor   (damping_factor),
        .threshold        (threshold),
        .pagerank         (pagerank),
        .pagerank_complete(pagerank_complete)
    );

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic do_reset;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic start_run;
        @(negedge clock);
        pagerank_enable = 1'b1;
        @(posedge clock);
        @(negedge clock);
        pagerank_enable = 1'b0;
    endtask

    // Counts posedges after the enable edge until pagerank_complete, bounded.
    task automatic wait_complete(input int start, input int limit, output int cycles);
        cycles = start;
        while (cycles < limit) begin
            @(posedge clock);
            cycles++;
            #1;
            if (pagerank_complete) break;
        end
    endtask

    task automatic load_dangling;
        for (int i = 0; i < T; i++) begin
            source_id[i][0]  = 32'(i);
            out_degree[i][0] = 32'd0;
            for (int k = 0; k < S; k++) dest_id[i][0][k] = 32'((i + 1) % N);
        end
    endtask

    // Ring i -> i+1 with garbage beyond out_degree that must be ignored.
    task automatic load_ring;
        for (int i = 0; i < T; i++) begin
            source_id[i][0]  = 32'(i);
            out_degree[i][0] = 32'd1;
            dest_id[i][0][0] = 32'((i + 1) % N);
            dest_id[i][0][1] = 32'((i + 5) % N);
            dest_id[i][0][2] = 32'd40;
        end
    endtask

    task automatic load_graph(input bit shuffled);
        int id;
        int deg;
        for (int s = 0; s < T; s++) begin
            id = s;
            if (shuffled) begin
                case (s)
                    7:  id = 8;
                    8:  id = 10;
                    9:  id = 7;
                    10: id = 9;
                    default: id = s;
                endcase
            end
            deg = (id == 19) ? 0 : 1 + id % 3;
            source_id[s][0]  = 32'(id);
            out_degree[s][0] = 32'(deg);
            dest_id[s][0][0] = (deg > 0) ? 32'((id + 1) % 19) : 32'd0;
            dest_id[s][0][1] = (deg > 1) ? 32'((id + 3) % 19) : 32'd0;
            dest_id[s][0][2] = (deg > 2) ? 32'((id + 7) % 19) : 32'd0;
        end
    endtask

    task automatic check_all_zero(input string name);
        bit bad = 1'b0;
        for (int v = 0; v < N; v++) if (pagerank[v] != 0.0) bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s: pagerank[0]=%g pagerank[19]=%g, required all 0.0", name, pagerank[0], pagerank[19]);
        end
        vectors++;
        if (pagerank_complete !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_complete: got %b required 0", name, pagerank_complete);
        end
    endtask

    task automatic test_reset;
        reset_n         = 1'b0;
        pagerank_enable = 1'b0;
        damping_factor  = 0.85;
        threshold       = 1e-5;
        load_dangling();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        vectors++;
        if (dut.pagerank_computation.iteration_number !== 0 || dut.pagerank_computation.delta != 0.0) begin
            miscompares++;
            $display("FAIL reset_state: iteration=%0d delta=%g required 0 and 0.0",
                     dut.pagerank_computation.iteration_number, dut.pagerank_computation.delta);
        end
    endtask

    task automatic test_idle;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        check_all_zero("idle");
    endtask

    task automatic test_dangling;
        int  cycles;
        bit  bad;
        do_reset();
        load_dangling();
        threshold = 1e-5;
        start_run();
        cycles = 0;
        repeat (22) begin
            @(posedge clock);
            cycles++;
        end
        #1;
        bad = 1'b0;
        for (int v = 0; v < N; v++) if (rabs(pagerank[v] - 0.0075) > 1e-12) bad = 1'b1;
        vectors++;
        if (bad || pagerank_complete !== 1'b0) begin
            miscompares++;
            $display("FAIL dangling_iter0_rank: pagerank[0]=%g complete=%b required 0.0075 and 0", pagerank[0], pagerank_complete);
        end
        vectors++;
        if (rabs(dut.pagerank_computation.delta - 0.85) > 1e-9) begin
            miscompares++;
            $display("FAIL dangling_iter0_delta: got %g required 0.85", dut.pagerank_computation.delta);
        end
        wait_complete(cycles, 200, cycles);
        vectors++;
        if (pagerank_complete !== 1'b1 || cycles != 43) begin
            miscompares++;
            $display("FAIL dangling_cycles: got %0d (complete=%b) required 43", cycles, pagerank_complete);
        end
        vectors++;
        if (dut.pagerank_computation.iteration_number !== 1 || dut.pagerank_computation.delta != 0.0) begin
            miscompares++;
            $display("FAIL dangling_final: iteration=%0d delta=%g required 1 and 0.0",
                     dut.pagerank_computation.iteration_number, dut.pagerank_computation.delta);
        end
    endtask

    task automatic test_ring;
        int cycles;
        bit bad;
        do_reset();
        load_ring();
        threshold = 1e-5;
        start_run();
        wait_complete(0, 200, cycles);
        vectors++;
        if (pagerank_complete !== 1'b1 || cycles != 22) begin
            miscompares++;
            $display("FAIL ring_cycles: got %0d (complete=%b) required 22", cycles, pagerank_complete);
        end
        bad = 1'b0;
        for (int v = 0; v < N; v++) if (rabs(pagerank[v] - 0.05) > 1e-12) bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL ring_rank: pagerank[0]=%g pagerank[7]=%g required 0.05", pagerank[0], pagerank[7]);
        end
        vectors++;
        if (dut.pagerank_computation.iteration_number !== 0 || dut.pagerank_computation.delta > 1e-12) begin
            miscompares++;
            $display("FAIL ring_final: iteration=%0d delta=%g required 0 and 0.0",
                     dut.pagerank_computation.iteration_number, dut.pagerank_computation.delta);
        end
    endtask

    task automatic test_graph;
        int cycles;
        bit bad;
        do_reset();
        load_graph(1'b0);
        threshold = 1e-5;
        start_run();
        wait_complete(0, 30000, cycles);
        ref_cycles = cycles;
        for (int v = 0; v < N; v++) ref_rank[v] = pagerank[v];
        vectors++;
        if (pagerank_complete !== 1'b1 || dut.pagerank_computation.delta >= 1e-5) begin
            miscompares++;
            $display("FAIL graph_sorted_converge: complete=%b delta=%g required 1 and <1e-5",
                     pagerank_complete, dut.pagerank_computation.delta);
        end
        bad = 1'b0;
        for (int v = 0; v < N; v++) if (pagerank[v] < 0.0075 - 1e-12) bad = 1'b1;
        vectors++;
        if (bad || rabs(pagerank[19] - 0.0075) > 1e-12) begin
            miscompares++;
            $display("FAIL graph_floor: pagerank[19]=%g required 0.0075, all >= 0.0075", pagerank[19]);
        end
        vectors++;
        if (cycles != 1 + (dut.pagerank_computation.iteration_number + 1) * 21) begin
            miscompares++;
            $display("FAIL graph_latency: got %0d required %0d", cycles,
                     1 + (dut.pagerank_computation.iteration_number + 1) * 21);
        end

        do_reset();
        load_graph(1'b1);
        start_run();
        wait_complete(0, 30000, cycles);
        bad = 1'b0;
        for (int v = 0; v < N; v++) if (rabs(pagerank[v] - ref_rank[v]) > 1e-9) bad = 1'b1;
        vectors++;
        if (pagerank_complete !== 1'b1 || bad) begin
            miscompares++;
            $display("FAIL graph_shuffled: complete=%b pagerank[8]=%g required 1 and %g",
                     pagerank_complete, pagerank[8], ref_rank[8]);
        end
    endtask

    task automatic test_done_hold;
        bit bad;
        int iter;
        iter = dut.pagerank_computation.iteration_number;
        start_run();
        repeat (25) @(posedge clock);
        #1;
        bad = 1'b0;
        for (int v = 0; v < N; v++) if (rabs(pagerank[v] - ref_rank[v]) > 1e-9) bad = 1'b1;
        vectors++;
        if (pagerank_complete !== 1'b1 || bad || dut.pagerank_computation.iteration_number !== iter) begin
            miscompares++;
            $display("FAIL done_hold: complete=%b iteration=%0d required 1 and %0d",
                     pagerank_complete, dut.pagerank_computation.iteration_number, iter);
        end
    endtask

    task automatic test_reset_mid;
        int cycles;
        bit bad;
        do_reset();
        load_graph(1'b0);
        start_run();
        repeat (10) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clock);
        reset_n = 1'b1;
        start_run();
        wait_complete(0, 30000, cycles);
        bad = 1'b0;
        for (int v = 0; v < N; v++) if (rabs(pagerank[v] - ref_rank[v]) > 1e-12) bad = 1'b1;
        vectors++;
        if (pagerank_complete !== 1'b1 || bad || cycles != ref_cycles) begin
            miscompares++;
            $display("FAIL mid_reset_rerun: cycles=%0d complete=%b required %0d and 1", cycles, pagerank_complete, ref_cycles);
        end
    endtask

    task automatic test_cap;
        int cycles;
        do_reset();
        load_ring();
        threshold = 0.0;
        start_run();
        wait_complete(0, 30000, cycles);
        vectors++;
        if (pagerank_complete !== 1'b1 || cycles != 21001) begin
            miscompares++;
            $display("FAIL cap_cycles: got %0d (complete=%b) required 21001", cycles, pagerank_complete);
        end
        vectors++;
        if (dut.pagerank_computation.iteration_number !== 999) begin
            miscompares++;
            $display("FAIL cap_iteration: got %0d required 999", dut.pagerank_computation.iteration_number);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_dangling();
        test_ring();
        test_graph();
        test_done_hold();
        test_reset_mid();
        test_cap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
